// File: rtl/tridiag_pkg.sv
// Shared definitions for the tridiagonal determinant front end: FSM state codes
// and the layout of the serial coefficient stream.
package tridiag_pkg;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // Word offsets inside the stream: b[0..N-1], then a[0..N-2], then c[0..N-2]
   localparam int B_BASE = 0;

   function automatic int a_base(input int n);
      return n;
   endfunction

   function automatic int c_base(input int n);
      return 2 * n - 1;
   endfunction

   function automatic int num_words(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/tridiag_det_loader.sv
// Serial coefficient loader and transaction sequencer for the tridiagonal
// determinant engine: packs a/b/c, starts the engine, returns the determinant.
module tridiag_det_loader
   import tridiag_pkg::*;
#(
   parameter int N     = 16,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2*WIDTH-1:0]       out_det,
   output logic                     busy,
   output logic                     eng_start,
   input  logic                     eng_done,
   input  logic [2*WIDTH-1:0]       eng_det,
   output logic [WIDTH*(N-1)-1:0]   a_flat,
   output logic [WIDTH*N-1:0]       b_flat,
   output logic [WIDTH*(N-1)-1:0]   c_flat
);

   localparam int NW    = num_words(N);
   localparam int CW    = $clog2(3 * N);
   localparam int A_LSB = a_base(N) * WIDTH;
   localparam int B_LSB = B_BASE * WIDTH;
   localparam int C_LSB = c_base(N) * WIDTH;
   localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);

   logic [1:0]            state_r;
   logic [1:0]            state_nxt_s;
   logic [CW-1:0]         cnt_r;
   logic [CW-1:0]         cnt_nxt_s;
   logic                  hs_s;
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic                  eng_start_r;
   logic                  busy_r;
   logic [2*WIDTH-1:0]    out_det_r;
   logic [WIDTH*NW-1:0]   coef_r;

   assign hs_s = in_valid && in_ready_r && (state_r == ST_LOAD);

   // Next-state and word-counter logic
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ST_LOAD: begin
            if (hs_s) begin
               if (cnt_r == LAST_WORD) begin
                  state_nxt_s = ST_START;
                  cnt_nxt_s   = {CW{1'b0}};
               end else begin
                  state_nxt_s = ST_LOAD;
                  cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
               end
            end else begin
               state_nxt_s = ST_LOAD;
               cnt_nxt_s   = cnt_r;
            end
         end
         ST_START: state_nxt_s = ST_WAIT;
         ST_WAIT: begin
            if (eng_done) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            if (out_valid_r && out_ready) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_LOAD;
            cnt_nxt_s   = {CW{1'b0}};
         end
      endcase
   end

   // State register; handshake and status outputs are decoded from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_LOAD;
         cnt_r       <= {CW{1'b0}};
         in_ready_r  <= 1'b1;
         eng_start_r <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         in_ready_r  <= (state_nxt_s == ST_LOAD);
         eng_start_r <= (state_nxt_s == ST_START);
         out_valid_r <= (state_nxt_s == ST_RESP);
         busy_r      <= !((state_nxt_s == ST_LOAD) && (cnt_nxt_s == {CW{1'b0}}));
      end
   end

   // Determinant capture; done outside WAIT never reaches the result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_det_r <= {(2*WIDTH){1'b0}};
      end else if ((state_r == ST_WAIT) && eng_done) begin
         out_det_r <= eng_det;
      end
   end

   // Coefficient store, one slice per accepted word in stream order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coef_r <= {(WIDTH*NW){1'b0}};
      end else if (hs_s) begin
         coef_r[int'(cnt_r) * WIDTH +: WIDTH] <= in_data;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_det   = out_det_r;
   assign eng_start = eng_start_r;
   assign busy      = busy_r;
   assign b_flat    = coef_r[B_LSB +: WIDTH*N];
   assign a_flat    = coef_r[A_LSB +: WIDTH*(N-1)];
   assign c_flat    = coef_r[C_LSB +: WIDTH*(N-1)];

endmodule

// File: tb/tb_tridiag_det_loader.sv
// Directed bench for tridiag_det_loader: an N=3 and an N=16 instance, each paired
// with a behavioural engine that evaluates the continuant of the packed vectors.
module tb_tridiag_det_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid3, in_valid16, out_ready;

   logic        in_ready3, out_valid3, busy3, eng_start3, eng_done3;
   logic [31:0] out_det3, eng_det3;
   logic [31:0] a_flat3, c_flat3;
   logic [47:0] b_flat3;

   logic         in_ready16, out_valid16, busy16, eng_start16, eng_done16;
   logic [31:0]  out_det16, eng_det16;
   logic [239:0] a_flat16, c_flat16;
   logic [255:0] b_flat16;

   logic        m_done3, m_done16, inj_done3;
   logic [31:0] m_det3, m_det16;
   int          m_cnt3, m_cnt16;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          hs_cnt;
   logic [15:0] words[$];

   always #5 clk = ~clk;

   assign eng_done3  = m_done3 | inj_done3;
   assign eng_det3   = inj_done3 ? 32'hDEAD_BEEF : m_det3;
   assign eng_done16 = m_done16;
   assign eng_det16  = m_det16;

   tridiag_det_loader #(.N(3), .WIDTH(16)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data),
      .out_valid(out_valid3), .out_ready(out_ready), .out_det(out_det3), .busy(busy3),
      .eng_start(eng_start3), .eng_done(eng_done3), .eng_det(eng_det3),
      .a_flat(a_flat3), .b_flat(b_flat3), .c_flat(c_flat3)
   );

   tridiag_det_loader #(.N(16), .WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data),
      .out_valid(out_valid16), .out_ready(out_ready), .out_det(out_det16), .busy(busy16),
      .eng_start(eng_start16), .eng_done(eng_done16), .eng_det(eng_det16),
      .a_flat(a_flat16), .b_flat(b_flat16), .c_flat(c_flat16)
   );

   // Continuant recurrence f_k = b_k*f_(k-1) - a_(k-1)*c_(k-1)*f_(k-2)
   function automatic logic [31:0] tri_det(input logic [255:0] b, input logic [239:0] a,
                                           input logic [239:0] c, input int n);
      longint fm2, fm1, fk, bv, av, cv;
      fm2 = 1;
      fm1 = longint'($signed(b[15:0]));
      for (int k = 1; k < n; k++) begin
         bv  = longint'($signed(b[k*16 +: 16]));
         av  = longint'($signed(a[(k-1)*16 +: 16]));
         cv  = longint'($signed(c[(k-1)*16 +: 16]));
         fk  = bv * fm1 - av * cv * fm2;
         fm2 = fm1;
         fm1 = fk;
      end
      return fm1[31:0];
   endfunction

   // Engine models: result three cycles after start, computed from the flats
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt3 <= 0; m_done3 <= 1'b0; m_det3 <= 32'h0;
      end else begin
         m_done3 <= 1'b0;
         if (eng_start3) begin
            m_cnt3 <= 3;
            m_det3 <= tri_det({208'h0, b_flat3}, {208'h0, a_flat3}, {208'h0, c_flat3}, 3);
         end else if (m_cnt3 != 0) begin
            m_cnt3 <= m_cnt3 - 1;
            if (m_cnt3 == 1) m_done3 <= 1'b1;
         end
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt16 <= 0; m_done16 <= 1'b0; m_det16 <= 32'h0;
      end else begin
         m_done16 <= 1'b0;
         if (eng_start16) begin
            m_cnt16 <= 3;
            m_det16 <= tri_det(b_flat16, a_flat16, c_flat16, 16);
         end else if (m_cnt16 != 0) begin
            m_cnt16 <= m_cnt16 - 1;
            if (m_cnt16 == 1) m_done16 <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Push words[] into the chosen instance; called and returns at a negedge
   task automatic feed(input bit sel16, input bit gaps);
      int   i = 0;
      int   guard = 0;
      logic vld, rdy;
      while (i < words.size() && guard < 400) begin
         vld = !(gaps && (guard % 2 == 1));
         in_data = words[i];
         if (sel16) in_valid16 = vld; else in_valid3 = vld;
         rdy = sel16 ? in_ready16 : in_ready3;
         @(posedge clk);
         if (vld && rdy) begin
            i++;
            hs_cnt++;
         end
         @(negedge clk);
         guard++;
      end
      in_valid3  = 1'b0;
      in_valid16 = 1'b0;
      chk("feed_count", 64'(i), 64'(words.size()));
   endtask

   task automatic wait_resp(input bit sel16, input logic [31:0] exp, input int hold);
      int t = 0;
      while (!(sel16 ? out_valid16 : out_valid3) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("resp_valid", 64'(sel16 ? out_valid16 : out_valid3), 64'd1);
      chk("resp_det", 64'(sel16 ? out_det16 : out_det3), 64'(exp));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_valid", 64'(out_valid3), 64'd1);
         chk("bp_det", 64'(out_det3), 64'(exp));
         chk("bp_in_ready", 64'(in_ready3), 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_in_ready", 64'(sel16 ? in_ready16 : in_ready3), 64'd1);
      chk("post_valid", 64'(sel16 ? out_valid16 : out_valid3), 64'd0);
      chk("post_busy", 64'(sel16 ? busy16 : busy3), 64'd0);
   endtask

   task automatic load_basic();
      words = '{16'd2, 16'd3, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1};
   endtask

   initial begin
      rst = 1'b1; in_data = 16'h0; in_valid3 = 1'b0; in_valid16 = 1'b0;
      out_ready = 1'b0; inj_done3 = 1'b0; hs_cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready3), 64'd1);
      chk("rst_out_valid", 64'(out_valid3), 64'd0);
      chk("rst_out_det", 64'(out_det3), 64'd0);
      chk("rst_eng_start", 64'(eng_start3), 64'd0);
      chk("rst_busy", 64'(busy3), 64'd0);
      chk("rst_b_flat", 64'(b_flat3), 64'd0);

      // Stray done while idle in LOAD
      inj_done3 = 1'b1;
      @(negedge clk);
      inj_done3 = 1'b0;
      chk("load_done_valid", 64'(out_valid3), 64'd0);
      chk("load_done_ready", 64'(in_ready3), 64'd1);
      chk("load_done_busy", 64'(busy3), 64'd0);

      // Basic set, stray done in START, then backpressure in RESP
      load_basic();
      feed(1'b0, 1'b0);
      chk("basic_start_lat", 64'(eng_start3), 64'd1);
      chk("basic_busy", 64'(busy3), 64'd1);
      chk("basic_in_ready", 64'(in_ready3), 64'd0);
      chk("basic_b_flat", 64'(b_flat3), 64'h0004_0003_0002);
      chk("basic_a_flat", 64'(a_flat3), 64'h0001_0001);
      chk("basic_c_flat", 64'(c_flat3), 64'h0001_0001);
      inj_done3 = 1'b1;
      @(negedge clk);
      inj_done3 = 1'b0;
      chk("start_one_cycle", 64'(eng_start3), 64'd0);
      chk("start_done_valid", 64'(out_valid3), 64'd0);
      chk("wait_in_ready", 64'(in_ready3), 64'd0);
      wait_resp(1'b0, 32'd18, 5);

      // Negative coefficients with in_valid toggling
      words = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0};
      feed(1'b0, 1'b1);
      chk("gaps_start_lat", 64'(eng_start3), 64'd1);
      chk("gaps_b_flat", 64'(b_flat3), 64'hFFFF_FFFF_FFFF);
      wait_resp(1'b0, 32'hFFFF_FFFF, 0);

      // Reset after four words, then a full reload
      words = '{16'd2, 16'd3, 16'd4, 16'd1};
      feed(1'b0, 1'b0);
      chk("mid_busy", 64'(busy3), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_b_flat", 64'(b_flat3), 64'd0);
      chk("mid_rst_a_flat", 64'(a_flat3), 64'd0);
      chk("mid_rst_start", 64'(eng_start3), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready3), 64'd1);
      chk("post_rst_busy", 64'(busy3), 64'd0);
      chk("post_rst_start", 64'(eng_start3), 64'd0);
      chk("post_rst_c_flat", 64'(c_flat3), 64'd0);
      load_basic();
      feed(1'b0, 1'b0);
      chk("reload_start_lat", 64'(eng_start3), 64'd1);
      wait_resp(1'b0, 32'd18, 0);

      // N=16 one-dimensional Laplacian
      words.delete();
      for (int k = 0; k < 16; k++) words.push_back(16'd2);
      for (int k = 0; k < 30; k++) words.push_back(16'hFFFF);
      hs_cnt = 0;
      feed(1'b1, 1'b0);
      chk("full_words", 64'(hs_cnt), 64'd46);
      chk("full_start_lat", 64'(eng_start16), 64'd1);
      chk("full_in_ready", 64'(in_ready16), 64'd0);
      wait_resp(1'b1, 32'd17, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tridiag_det_loader.md
Name: tridiag_det_loader

Overview:
- Front-end driver for the tridiagonal determinant engine.
- Accepts the matrix coefficients as a serial valid/ready word stream and packs them into the engine's flattened a/b/c vectors.
- Once the set is complete, pulses the engine start, waits for engine done, captures the determinant, and returns it on a valid/ready response port.
- Sits between the host/bus adapter and the determinant engine; it owns the engine's inputs for the whole transaction.

Parameters:
- N, 16, matrix order; legal range 3..16; must match the engine instance.
- WIDTH, 16, coefficient width in bits; the determinant is 2*WIDTH bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  coefficient word valid
- in_ready  output  1  loader can accept a coefficient word
- in_data  input  WIDTH  signed coefficient word
- out_valid  output  1  determinant result valid
- out_ready  input  1  consumer accepts result
- out_det  output  2*WIDTH  signed determinant result
- busy  output  1  high in every state except LOAD with word count 0
- eng_start  output  1  one-cycle start pulse to the engine
- eng_done  input  1  engine completion pulse
- eng_det  input  2*WIDTH  engine determinant; valid in the cycle eng_done=1
- a_flat  output  WIDTH*(N-1)  sub-diagonal a[0..N-2], a[0] at LSBs
- b_flat  output  WIDTH*N  main diagonal b[0..N-1], b[0] at LSBs
- c_flat  output  WIDTH*(N-1)  super-diagonal c[0..N-2], c[0] at LSBs

Behaviour:
- Stream order is fixed: b[0..N-1], then a[0..N-2], then c[0..N-2]. Total 3N-2 words.
- The word counter is $clog2(3N) bits wide. Word k is written into its slice on the handshake (in_valid & in_ready).
- FSM states: LOAD, START, WAIT, RESP.
  - LOAD: in_ready=1. Each handshake increments the counter. The handshake on word 3N-3 goes to START and clears the counter.
  - START: eng_start=1 for exactly this one cycle; then go to WAIT. Latency is one cycle from the last input handshake to eng_start.
  - WAIT: in_ready=0. When eng_done=1, register eng_det into out_det and go to RESP.
  - RESP: out_valid=1 and out_det is held stable. On out_valid & out_ready, go to LOAD; in_ready=1 on the next cycle.
- eng_done outside WAIT is ignored, including a pulse in the START cycle.
- a_flat, b_flat and c_flat are written only in LOAD. They are stable from START through the end of RESP, as the engine requires.
- Gaps in in_valid stall loading with no state change. Words are never dropped or duplicated.
- out_det is sign-preserving and not modified after capture; eng_det is passed through with no truncation.
- Reset values, asserted at any time including mid-load or mid-compute:
  - state=LOAD, counter=0, in_ready=1 after reset deassertion.
  - out_valid=0, out_det=0, eng_start=0, busy=0.
  - a_flat, b_flat and c_flat all zero.
  - The engine shares rst, so no stale done is expected. A stray eng_done after reset is ignored because state is LOAD.
- No hang protection. If eng_done never arrives, the block stays in WAIT until reset.

Decomposition:
- Shared package tridiag_pkg:
  - state encoding constants LOAD/START/WAIT/RESP
  - function num_words(N) = 3N-2
  - slice-offset constants: b base 0, a base N, c base 2N-1
- No sub-module. A top-level wrapper tridiag_det_top, instantiating this loader plus the engine, is natural for integration and tests.

Test Plan:
- Basic: N=3, W=16. Stream b=[2,3,4], a=[1,1], c=[1,1] with in_valid held high. Expect eng_start one cycle after the 7th handshake, then out_valid with out_det=18.
- Signs and gaps: N=3. Stream b=[-1,-1,-1], a=[0,0], c=[0,0] with in_valid toggling every other cycle. Expect out_det=-1 (0xFFFFFFFF); the packed b_flat equals 0xFFFF_FFFF_FFFF.
- Backpressure: hold out_ready=0 for 5 cycles in RESP. Expect out_valid=1, out_det stable, in_ready=0 throughout. Expect in_ready=1 the cycle after out_ready=1 with out_valid=1.
- Reset mid-load: after 4 words assert rst for 2 cycles. Expect flats=0, in_ready=1, no eng_start. A full reload of the Basic set then yields 18.
- Spurious done: pulse eng_done in LOAD and in START. Expect no state change and no out_valid; the later real done still yields the correct result.
- Full size: N=16, b[i]=2, a=c=-1 (the 1D Laplacian). Expect out_det=17 and exactly 46 accepted words.
